// File: rtl/led_blink_ctrl.sv
// led_blink_ctrl: memory-mapped LED controller with per-channel blink,
// programmable blink divider, register readback and selectable polarity.
// Optional PWM dimming is compiled in when LED_BLINK_CTRL_PWM_EN is defined.
// Register map (addr[3:2]): 0 DATA, 1 BLINK, 2 DIV, 3 PWM duty (or reads 0).
module led_blink_ctrl #(
  parameter int N_LED      = 32,
  parameter int DIV_W      = 32,
  parameter int DIV_RST    = 24999999,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic [3:0]       addr,
  input  logic [3:0]       byteen,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata,
  output logic [N_LED-1:0] led_out
);

  localparam logic [DIV_W-1:0] DIV_RST_V = DIV_W'(DIV_RST);
  localparam logic [N_LED-1:0] LED_OFF   = {N_LED{ACTIVE_LOW}};

  logic [1:0]       sel;
  logic [31:0]      wmask;
  logic             wr_data, wr_blink, wr_div;
  logic [31:0]      data_ext, blink_ext, div_ext, reg3_rd;

  logic [N_LED-1:0] data_q, data_d;
  logic [N_LED-1:0] blink_q, blink_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             phase_q, phase_d;
  logic [N_LED-1:0] led_q, led_d;
  logic [N_LED-1:0] lit;
  logic             gate;

  // addr[1:0] is a byte offset inside a word register and is not decoded
  logic unused_addr;
  assign unused_addr = ^addr[1:0];

  assign sel       = addr[3:2];
  assign wr_data   = we && (sel == 2'd0);
  assign wr_blink  = we && (sel == 2'd1);
  // a DIV write with no lanes enabled changes nothing, so it must not restart the timebase
  assign wr_div    = we && (sel == 2'd2) && (byteen != 4'b0000);
  assign data_ext  = 32'(data_q);
  assign blink_ext = 32'(blink_q);
  assign div_ext   = 32'(div_q);

  // expand byte enables into a bit mask
  always_comb begin
    wmask = '0;
    for (int k = 0; k < 4; k++) begin
      wmask[8*k +: 8] = {8{byteen[k]}};
    end
  end

  // lane-merged register updates; bits beyond the register width are dropped
  always_comb begin
    data_d  = data_q;
    blink_d = blink_q;
    div_d   = div_q;
    if (wr_data)  data_d  = N_LED'((data_ext  & ~wmask) | (wdata & wmask));
    if (wr_blink) blink_d = N_LED'((blink_ext & ~wmask) | (wdata & wmask));
    if (wr_div)   div_d   = DIV_W'((div_ext   & ~wmask) | (wdata & wmask));
  end

  // blink timebase; a DIV write restarts it and wins over a coincident wrap
  always_comb begin
    cnt_d   = cnt_q + DIV_W'(1);
    phase_d = phase_q;
    if (wr_div) begin
      cnt_d   = '0;
      phase_d = 1'b0;
    end else if (cnt_q == div_q) begin
      cnt_d   = '0;
      phase_d = ~phase_q;
    end
  end

`ifdef LED_BLINK_CTRL_PWM_EN
  logic [7:0] duty_q, duty_d;
  logic [7:0] pwm_cnt_q;

  assign duty_d  = (we && (sel == 2'd3) && byteen[0]) ? wdata[7:0] : duty_q;
  // full duty bypasses the compare so 8'hFF has no off slot
  assign gate    = (duty_q == 8'hFF) || (pwm_cnt_q < duty_q);
  assign reg3_rd = {24'h0, duty_q};

  // duty register and free-running PWM counter
  always_ff @(posedge clk) begin
    if (reset) begin
      duty_q    <= 8'hFF;
      pwm_cnt_q <= 8'h00;
    end else begin
      duty_q    <= duty_d;
      pwm_cnt_q <= pwm_cnt_q + 8'd1;
    end
  end
`else
  assign gate    = 1'b1;
  assign reg3_rd = 32'h0;
`endif

  // channel is lit when on and either steady or in the blink on-phase
  always_comb begin
    lit   = data_q & (~blink_q | {N_LED{phase_q}}) & {N_LED{gate}};
    led_d = ACTIVE_LOW ? ~lit : lit;
  end

  // register state and pin drive
  always_ff @(posedge clk) begin
    if (reset) begin
      data_q  <= '0;
      blink_q <= '0;
      div_q   <= DIV_RST_V;
      cnt_q   <= '0;
      phase_q <= 1'b0;
      led_q   <= LED_OFF;
    end else begin
      data_q  <= data_d;
      blink_q <= blink_d;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
      led_q   <= led_d;
    end
  end

  // combinational readback of the addressed register
  always_comb begin
    case (sel)
      2'd0:    rdata = data_ext;
      2'd1:    rdata = blink_ext;
      2'd2:    rdata = div_ext;
      default: rdata = reg3_rd;
    endcase
  end

  assign led_out = led_q;

endmodule

// File: doc/led_blink_ctrl.md
Name: led_blink_ctrl

Overview:
Memory-mapped LED controller with N_LED channels. It is the parametrised successor of the single 32-bit LED latch. It adds per-channel blink, a programmable blink divider, register readback and selectable output polarity. It sits on the peripheral bus next to the other MMIO devices and drives the board LED pins directly.

Parameters:
N_LED, 32, number of LED channels (1..32); register bits at and above N_LED are not stored and read 0
DIV_W, 32, width of the blink divider register and its counter (1..32)
DIV_RST, 24999999, reset value of DIV (half-period minus 1, in clk cycles); truncated to DIV_W bits
ACTIVE_LOW, 1, 1: lit LED drives 0 on led_out; 0: lit LED drives 1

Ports:
clk  input  1  system clock; all state updates on the rising edge
reset  input  1  synchronous, active-high reset
we  input  1  bus write strobe, qualified by byteen
addr  input  4  byte address; only addr[3:2] decoded, addr[1:0] ignored
byteen  input  4  byte-lane write enables; lane k covers bits [8k+7:8k]
wdata  input  32  write data
rdata  output  32  combinational read data for addr
led_out  output  N_LED  registered LED pin drive

Behaviour:
- Register map, by addr[3:2]:
  - 0: DATA, on/off per channel, reset 0
  - 1: BLINK, per-channel blink enable, reset 0
  - 2: DIV, half-period minus 1, reset DIV_RST
  - 3: PWM (see Optional Feature); otherwise reads 0 and writes are ignored
- Write: on a clk edge with we=1, each lane k with byteen[k]=1 updates that lane of the addressed register. Lanes with byteen[k]=0 hold. we=1 with byteen=0 is a no-op. Bits at or above N_LED (DATA/BLINK) or DIV_W (DIV) are dropped.
- Read: rdata = addressed register, zero-extended, combinational, independent of we. A read in the same cycle as a write returns the old value.
- Blink timebase: cnt (DIV_W bits) and phase (1 bit), both reset to 0. Every cycle:
  - if cnt == DIV: cnt <= 0 and phase <= ~phase
  - else: cnt <= cnt + 1
  - DIV=0: phase toggles every cycle.
- Any write touching DIV (we=1, addr[3:2]=2, byteen != 0) forces cnt <= 0 and phase <= 0 at that edge. This overrides a simultaneous wrap. The new DIV applies from the next cycle.
- lit[i] = DATA[i] & (~BLINK[i] | phase).
- led_out <= ACTIVE_LOW ? ~lit : lit, registered. Visible output lags a DATA/BLINK write by exactly 1 cycle.
- Reset:
  - all registers go to their reset values, cnt=0, phase=0
  - led_out = all 1s if ACTIVE_LOW, all 0s otherwise (all LEDs off)
  - reset asserted mid-blink or mid-write discards the write and restarts the timebase from 0
- A DATA write and a phase toggle on the same edge are independent; led_out reflects both one cycle later.

Optional Feature:
- Macro: LED_BLINK_CTRL_PWM_EN.
- When defined:
  - register 3 is PWM: bits [7:0] are duty, reset 8'hFF, other bits read 0.
  - An 8-bit free-running pwm_cnt, reset 0, increments every cycle and wraps 255 -> 0.
  - lit[i] is additionally ANDed with gate, where gate = (duty == 8'hFF) | (pwm_cnt < duty).
  - duty=0 holds all LEDs off. duty=8'hFF is fully on with no gaps.
- When undefined: no pwm_cnt, register 3 reads 0, gate is constant 1.

Test Plan:
1. Reset check: assert reset 2 cycles -> led_out=32'hFFFFFFFF (ACTIVE_LOW=1), rdata at 0x0=0, at 0x4=0, at 0x8=DIV_RST.
2. Byte-lane write: write DATA=32'hA5A5A5A5 with byteen=4'b1111, then DATA=32'h000000FF with byteen=4'b0001 -> DATA reads 32'hA5A5A5FF. led_out=32'h5A5A5A00 exactly one cycle after the second write.
3. Blink: DIV=3, BLINK=1, DATA=1 -> led_out[0] toggles every 4 cycles after the DIV write (low for 4 cycles after first wrap, then high for 4); led_out[31:1] unchanged.
4. DIV write vs. wrap: with DIV=2, write DIV=5 on the cycle cnt==2 -> no toggle at that edge, cnt=0, phase=0. Next toggle 6 cycles later.
5. Width limit: N_LED=8, write DATA=32'hFFFF_FF0F -> rdata=32'h0000000F, led_out=8'hF0.
6. PWM (macro defined): DATA=1, duty=8'h40 -> led_out[0] low for 64 of every 256 cycles. Duty=0 -> never low. Duty=8'hFF -> always low.
